// File: rtl/hello_pkg.sv
// Shared types and constants for the hello_led switch/LED block.
package hello_pkg;

  localparam int LED_W_DEF = 4;

  typedef logic [LED_W_DEF-1:0] led_t;

  localparam led_t LED_RESET   = '0;
  localparam led_t CHASE_RESET = 4'b0001;
  localparam led_t CHASE_CODE  = 4'b1111;

endpackage

// File: rtl/hello_divider.sv
// Free-running DIV_W-bit rate divider; tick is high for the one clock
// in which the count sits at all-ones, just before it wraps to zero.
module hello_divider #(
  parameter int DIV_W = 22
) (
  input  logic clck,
  input  logic rst_n,
  output logic tick
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == {DIV_W{1'b1}});

endmodule

// File: rtl/hello_led.sv
// iCEstick hello-world: LEDs mirror the switches one clock late.
// Define HELLO_CHASE_EN to show a rotating heartbeat while all switches are on.
module hello_led
  import hello_pkg::*;
#(
  parameter int LED_W = LED_W_DEF,
  parameter int DIV_W = 22
) (
  input  logic             clck,
  input  logic             rst_n,
  input  logic [LED_W-1:0] sw,
  output logic [LED_W-1:0] led
);

  if (DIV_W < 1) begin : g_div_w_check
    $error("hello_led: DIV_W must be at least 1");
  end

`ifdef HELLO_CHASE_EN
  logic             tick;
  logic             all_on;
  logic [LED_W-1:0] chase;

  assign all_on = (sw == LED_W'(CHASE_CODE));

  hello_divider #(
    .DIV_W (DIV_W)
  ) u_divider (
    .clck  (clck),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Chase position is retained while mirroring so the heartbeat resumes in place.
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      chase <= LED_W'(CHASE_RESET);
    end else if (tick && all_on) begin
      chase <= {chase[LED_W-2:0], chase[LED_W-1]};
    end
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_W'(LED_RESET);
    end else begin
      led <= all_on ? chase : sw;
    end
  end
`else
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_W'(LED_RESET);
    end else begin
      led <= sw;
    end
  end
`endif

endmodule

// File: tb/tb_hello_led.sv
// Self-checking bench for hello_led: randomized switch stimulus against a
// cycle-count based reference model; covers HELLO_CHASE_EN when defined.
module tb_hello_led;

  localparam int LED_W = 4;
  localparam int DIV_W = 2;
  localparam int PERIOD = 1 << DIV_W;

  logic             clck;
  logic             rst_n;
  logic [LED_W-1:0] sw;
  logic [LED_W-1:0] led;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset, chase position as an index.
  logic [LED_W-1:0] exp_led;
  int               cycles;
  int               chase_pos;

  hello_led #(
    .LED_W (LED_W),
    .DIV_W (DIV_W)
  ) dut (
    .clck  (clck),
    .rst_n (rst_n),
    .sw    (sw),
    .led   (led)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog led=%b expected=finish", led);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [LED_W-1:0] actual,
                             input logic [LED_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s led=%b expected=%b", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    exp_led   = '0;
    cycles    = 0;
    chase_pos = 0;
  endtask

  // Evaluate what one rising edge does, from the behavioural rules.
  task automatic modelEdge();
    bit tick;
    if (!rst_n) begin
      modelReset();
      return;
    end
    tick = ((cycles % PERIOD) == PERIOD - 1);
`ifdef HELLO_CHASE_EN
    if (sw == 4'd15) begin
      exp_led = 4'(1 << chase_pos);
      if (tick) chase_pos = (chase_pos + 1) % LED_W;
    end else begin
      exp_led = sw;
    end
`else
    exp_led = sw;
`endif
    cycles++;
  endtask

  // Called from a negedge: drive, take one rising edge, check at the next negedge.
  task automatic applyStimulus(input logic [LED_W-1:0] value, input string tag);
    sw = value;
    @(posedge clck);
    modelEdge();
    @(negedge clck);
    checkOutput(tag, led, exp_led);
  endtask

  initial begin
    logic [LED_W-1:0] value;
    rst_n = 1'b0;
    sw    = 4'b1010;
    modelReset();

    for (int i = 0; i < 3; i++) begin
      @(posedge clck);
      modelEdge();
      @(negedge clck);
      checkOutput("reset_hold", led, 4'b0000);
    end

    rst_n = 1'b1;
    applyStimulus(4'b1010, "reset_release");
    applyStimulus(4'b0000, "mirror_zero");
    applyStimulus(4'b0001, "mirror_one");

    sw = 4'b0010;
    #2;
    checkOutput("latency_pre_edge", led, 4'b0001);
    applyStimulus(4'b0010, "latency_post_edge");

    for (int v = 0; v < 16; v++) begin
`ifdef HELLO_CHASE_EN
      if (v == 15) continue;
`endif
      applyStimulus(4'(v), "sweep");
    end

    for (int i = 0; i < 60; i++) begin
      value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) value = 4'b1111;
      applyStimulus(value, "random");
    end

    applyStimulus(4'b0110, "pre_async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset", led, 4'b0000);
    @(posedge clck);
    @(negedge clck);
    checkOutput("async_reset_hold", led, 4'b0000);
    rst_n = 1'b1;
    applyStimulus(4'b0101, "after_reset");

    // Back to a clean reset so the all-ones phase starts at a known divider count.
    rst_n = 1'b0;
    @(negedge clck);
    modelReset();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b1111, "all_on");
    end
    applyStimulus(4'b0011, "leave_all_on");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1111, "all_on_resume");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
